// File: rtl/wash_seq_if.sv
// wash_seq_if: front-panel sequencer bus.
//   tick, btn_mode, btn_start : inputs to the sequencer, each a one-cycle strobe
//   ld_drw, fl_drw, ld_fsd    : LED vectors (phase lit, phase flashing, sub-step lit)
//   busy, done                : RUN/PAUSE and DONE indicators
// master = stimulus side (panel/divider), slave = sequencer.
interface wash_seq_if;
  logic       tick;
  logic       btn_mode;
  logic       btn_start;
  logic [2:0] ld_drw;
  logic [2:0] fl_drw;
  logic [2:0] ld_fsd;
  logic       busy;
  logic       done;

  modport master (
    output tick, btn_mode, btn_start,
    input  ld_drw, fl_drw, ld_fsd, busy, done
  );

  modport slave (
    input  tick, btn_mode, btn_start,
    output ld_drw, fl_drw, ld_fsd, busy, done
  );
endinterface

// File: rtl/wash_seq.sv
// wash_seq: washing-program sequencer feeding the front-panel LED driver.
// Walks the selected program's phases (wash, rinse, dry) and sub-steps
// (fill, spin, drain), advancing on the 1 Hz tick.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : wash_seq_if.slave (tick/buttons in, LED vectors and status out)
// All outputs are registered from the next-state values, so an input seen at
// edge t shows up on the outputs right after edge t.
//
// state   | meaning
// --------+---------------------------------------------
// S_IDLE  | program selection, ld_drw shows program mask
// S_RUN   | stepping through phases on each tick
// S_PAUSE | frozen, sub-step LEDs off
// S_DONE  | program finished, all LEDs off
module wash_seq #(
  parameter int T_FILL  = 3,
  parameter int T_WASH  = 9,
  parameter int T_RINSE = 6,
  parameter int T_DRY   = 6,
  parameter int T_DRAIN = 3,
  parameter int CW      = 8
) (
  input logic       clk,
  input logic       rst,
  wash_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;
  typedef enum logic [1:0] {PH_WASH, PH_RINSE, PH_DRY} phase_t;
  typedef enum logic [1:0] {ST_FILL, ST_SPIN, ST_DRAIN} step_t;

  // Counter reload values: a step of duration D counts D-1 down to 0.
  localparam logic [CW-1:0] L_FILL  = CW'(T_FILL - 1);
  localparam logic [CW-1:0] L_WASH  = CW'(T_WASH - 1);
  localparam logic [CW-1:0] L_RINSE = CW'(T_RINSE - 1);
  localparam logic [CW-1:0] L_DRY   = CW'(T_DRY - 1);
  localparam logic [CW-1:0] L_DRAIN = CW'(T_DRAIN - 1);

  state_t        state, state_n;
  phase_t        phase, phase_n;
  step_t         step, step_n;
  logic [2:0]    idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    mask;
  logic          phase_end;

  function automatic logic [2:0] prog_mask(input logic [2:0] i);
    case (i)
      3'd0:    prog_mask = 3'b111;
      3'd1:    prog_mask = 3'b001;
      3'd2:    prog_mask = 3'b011;
      3'd3:    prog_mask = 3'b010;
      3'd4:    prog_mask = 3'b110;
      3'd5:    prog_mask = 3'b100;
      default: prog_mask = 3'b111;
    endcase
  endfunction

  function automatic logic [CW-1:0] spin_load(input phase_t ph);
    case (ph)
      PH_WASH:  spin_load = L_WASH;
      PH_RINSE: spin_load = L_RINSE;
      default:  spin_load = L_DRY;
    endcase
  endfunction

  // Phases from ph upward; completed (lower) phases drop out of ld_drw.
  function automatic logic [2:0] live_phases(input phase_t ph);
    case (ph)
      PH_WASH:  live_phases = 3'b111;
      PH_RINSE: live_phases = 3'b110;
      PH_DRY:   live_phases = 3'b100;
      default:  live_phases = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] phase_vec(input phase_t ph);
    case (ph)
      PH_WASH:  phase_vec = 3'b001;
      PH_RINSE: phase_vec = 3'b010;
      PH_DRY:   phase_vec = 3'b100;
      default:  phase_vec = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] step_vec(input step_t st);
    case (st)
      ST_FILL:  step_vec = 3'b100;
      ST_SPIN:  step_vec = 3'b010;
      ST_DRAIN: step_vec = 3'b001;
      default:  step_vec = 3'b000;
    endcase
  endfunction

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    step_n    = step;
    idx_n     = idx;
    cnt_n     = cnt;
    phase_end = 1'b0;
    mask      = prog_mask(idx);
    case (state)
      S_IDLE: begin
        // start takes priority; a simultaneous mode pulse is dropped
        if (bus.btn_start) begin
          state_n = S_RUN;
          if (mask[0]) begin
            phase_n = PH_WASH;
            step_n  = ST_FILL;
            cnt_n   = L_FILL;
          end else if (mask[1]) begin
            phase_n = PH_RINSE;
            step_n  = ST_FILL;
            cnt_n   = L_FILL;
          end else begin
            phase_n = PH_DRY;
            step_n  = ST_SPIN;
            cnt_n   = L_DRY;
          end
        end else if (bus.btn_mode) begin
          idx_n = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end
      end
      S_RUN: begin
        // a tick coinciding with pause is discarded
        if (bus.btn_start) begin
          state_n = S_PAUSE;
        end else if (bus.tick) begin
          if (cnt != '0) begin
            cnt_n = cnt - CW'(1);
          end else begin
            case (step)
              ST_FILL: begin
                step_n = ST_SPIN;
                cnt_n  = spin_load(phase);
              end
              ST_SPIN: begin
                if (phase != PH_DRY) begin
                  step_n = ST_DRAIN;
                  cnt_n  = L_DRAIN;
                end else begin
                  phase_end = 1'b1;
                end
              end
              default: phase_end = 1'b1;
            endcase
          end
        end
        if (phase_end) begin
          if (phase == PH_WASH && mask[1]) begin
            phase_n = PH_RINSE;
            step_n  = ST_FILL;
            cnt_n   = L_FILL;
          end else if (phase != PH_DRY && mask[2]) begin
            phase_n = PH_DRY;
            step_n  = ST_SPIN;
            cnt_n   = L_DRY;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_PAUSE: begin
        if (bus.btn_start) state_n = S_RUN;
      end
      S_DONE: begin
        if (bus.btn_start || bus.btn_mode) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      phase      <= PH_WASH;
      step       <= ST_FILL;
      idx        <= 3'd0;
      cnt        <= '0;
      bus.ld_drw <= 3'b111;
      bus.fl_drw <= 3'b000;
      bus.ld_fsd <= 3'b000;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      step  <= step_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      case (state_n)
        S_IDLE: begin
          bus.ld_drw <= prog_mask(idx_n);
          bus.fl_drw <= 3'b000;
          bus.ld_fsd <= 3'b000;
          bus.busy   <= 1'b0;
          bus.done   <= 1'b0;
        end
        S_RUN: begin
          bus.ld_drw <= prog_mask(idx_n) & live_phases(phase_n);
          bus.fl_drw <= phase_vec(phase_n);
          bus.ld_fsd <= step_vec(step_n);
          bus.busy   <= 1'b1;
          bus.done   <= 1'b0;
        end
        S_PAUSE: begin
          bus.ld_drw <= prog_mask(idx_n) & live_phases(phase_n);
          bus.fl_drw <= phase_vec(phase_n);
          bus.ld_fsd <= 3'b000;
          bus.busy   <= 1'b1;
          bus.done   <= 1'b0;
        end
        default: begin
          bus.ld_drw <= 3'b000;
          bus.fl_drw <= 3'b000;
          bus.ld_fsd <= 3'b000;
          bus.busy   <= 1'b0;
          bus.done   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wash_seq.sv
// tb_wash_seq: scenario tasks for wash_seq plus a randomized run compared
// against a step-list reference model (program expanded into a list of
// (phase, step, duration) entries, consumed one tick at a time).
module tb_wash_seq;
  localparam int TF = 2, TW = 3, TR = 2, TDY = 2, TDN = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  wash_seq_if bus();

  wash_seq #(
    .T_FILL(TF), .T_WASH(TW), .T_RINSE(TR), .T_DRY(TDY), .T_DRAIN(TDN), .CW(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [10:0] obs;
  assign obs = {bus.ld_drw, bus.fl_drw, bus.ld_fsd, bus.busy, bus.done};

  // ---------------- reference model ----------------
  // m_state: 0 idle, 1 run, 2 pause, 3 done
  int masks [6] = '{7, 1, 3, 2, 6, 4};
  int m_state = 0;
  int m_idx   = 0;
  int seq_ph  [$];
  int seq_st  [$];   // LED bit of the step: fill 2, spin 1, drain 0
  int seq_dur [$];
  int pos = 0;
  int rem = 0;

  function automatic void build(input int mask);
    seq_ph.delete(); seq_st.delete(); seq_dur.delete();
    for (int ph = 0; ph < 3; ph++) begin
      if ((mask >> ph) & 1) begin
        if (ph < 2) begin
          seq_ph.push_back(ph); seq_st.push_back(2); seq_dur.push_back(TF);
          seq_ph.push_back(ph); seq_st.push_back(1); seq_dur.push_back(ph == 0 ? TW : TR);
          seq_ph.push_back(ph); seq_st.push_back(0); seq_dur.push_back(TDN);
        end else begin
          seq_ph.push_back(ph); seq_st.push_back(1); seq_dur.push_back(TDY);
        end
      end
    end
    pos = 0;
    rem = seq_dur[0];
  endfunction

  function automatic void model_update(input logic t, input logic m, input logic s, input logic r);
    if (r) begin
      m_state = 0;
      m_idx   = 0;
    end else begin
      case (m_state)
        0: if (s) begin
             build(masks[m_idx]);
             m_state = 1;
           end else if (m) m_idx = (m_idx + 1) % 6;
        1: if (s) m_state = 2;
           else if (t) begin
             rem--;
             if (rem == 0) begin
               pos++;
               if (pos == seq_ph.size()) m_state = 3;
               else rem = seq_dur[pos];
             end
           end
        2: if (s) m_state = 1;
        default: if (s || m) m_state = 0;
      endcase
    end
  endfunction

  function automatic logic [10:0] model_out();
    int ld, fl, fsd, by, dn;
    ld = 0; fl = 0; fsd = 0; by = 0; dn = 0;
    case (m_state)
      0: ld = masks[m_idx];
      1, 2: begin
        ld  = masks[m_idx] & ~((1 << seq_ph[pos]) - 1);
        fl  = 1 << seq_ph[pos];
        fsd = (m_state == 1) ? (1 << seq_st[pos]) : 0;
        by  = 1;
      end
      default: dn = 1;
    endcase
    return {3'(ld), 3'(fl), 3'(fsd), 1'(by), 1'(dn)};
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input logic t, input logic m, input logic s, input logic r);
    bus.tick = t; bus.btn_mode = m; bus.btn_start = s; rst = r;
    @(posedge clk);
    model_update(t, m, s, r);
    #1;
    bus.tick = 1'b0; bus.btn_mode = 1'b0; bus.btn_start = 1'b0; rst = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic modes(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== 11'b111_000_000_0_0) begin
      errors++; $display("FAIL reset got %b exp %b", obs, 11'b111_000_000_0_0);
    end
  endtask

  task automatic test_mode();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    modes(1);
    checks++;
    if (obs !== 11'b001_000_000_0_0) begin
      errors++; $display("FAIL mode_1 got %b exp %b", obs, 11'b001_000_000_0_0);
    end
    for (int i = 0; i < 4; i++) begin
      modes(1);
      checks++;
      if (obs !== {3'(masks[i + 2]), 8'b000_000_0_0}) begin
        errors++; $display("FAIL mode_walk got %b exp %b", obs, {3'(masks[i + 2]), 8'b000_000_0_0});
      end
    end
    checks++;
    if (obs !== 11'b100_000_000_0_0) begin
      errors++; $display("FAIL mode_5 got %b exp %b", obs, 11'b100_000_000_0_0);
    end
    modes(1);
    checks++;
    if (obs !== 11'b111_000_000_0_0) begin
      errors++; $display("FAIL mode_wrap got %b exp %b", obs, 11'b111_000_000_0_0);
    end
  endtask

  task automatic test_prog_wash_only();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    modes(1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== 11'b001_001_100_1_0) begin
      errors++; $display("FAIL p001_start got %b exp %b", obs, 11'b001_001_100_1_0);
    end
    ticks(2);
    checks++;
    if (obs !== 11'b001_001_010_1_0) begin
      errors++; $display("FAIL p001_spin got %b exp %b", obs, 11'b001_001_010_1_0);
    end
    ticks(3);
    checks++;
    if (obs !== 11'b001_001_001_1_0) begin
      errors++; $display("FAIL p001_drain got %b exp %b", obs, 11'b001_001_001_1_0);
    end
    ticks(1);
    checks++;
    if (obs !== 11'b000_000_000_0_1) begin
      errors++; $display("FAIL p001_done got %b exp %b", obs, 11'b000_000_000_0_1);
    end
  endtask

  task automatic test_prog_rinse_dry();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    modes(4);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== 11'b110_010_100_1_0) begin
      errors++; $display("FAIL p110_start got %b exp %b", obs, 11'b110_010_100_1_0);
    end
    ticks(5);
    checks++;
    if (obs !== 11'b100_100_010_1_0) begin
      errors++; $display("FAIL p110_dry got %b exp %b", obs, 11'b100_100_010_1_0);
    end
    ticks(1);
    checks++;
    if (obs !== 11'b100_100_010_1_0) begin
      errors++; $display("FAIL p110_dry_last got %b exp %b", obs, 11'b100_100_010_1_0);
    end
    ticks(1);
    checks++;
    if (obs !== 11'b000_000_000_0_1) begin
      errors++; $display("FAIL p110_done got %b exp %b", obs, 11'b000_000_000_0_1);
    end
  endtask

  task automatic test_pause();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== 11'b111_001_000_1_0) begin
      errors++; $display("FAIL pause_enter got %b exp %b", obs, 11'b111_001_000_1_0);
    end
    ticks(5);
    modes(1);
    checks++;
    if (obs !== 11'b111_001_000_1_0) begin
      errors++; $display("FAIL pause_frozen got %b exp %b", obs, 11'b111_001_000_1_0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== 11'b111_001_100_1_0) begin
      errors++; $display("FAIL pause_resume got %b exp %b", obs, 11'b111_001_100_1_0);
    end
    ticks(1);
    checks++;
    if (obs !== 11'b111_001_010_1_0) begin
      errors++; $display("FAIL pause_remaining got %b exp %b", obs, 11'b111_001_010_1_0);
    end
  endtask

  task automatic test_simultaneous();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== 11'b111_001_000_1_0) begin
      errors++; $display("FAIL tick_start_pause got %b exp %b", obs, 11'b111_001_000_1_0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(1);
    checks++;
    if (obs !== 11'b111_001_100_1_0) begin
      errors++; $display("FAIL tick_discarded got %b exp %b", obs, 11'b111_001_100_1_0);
    end
    ticks(1);
    checks++;
    if (obs !== 11'b111_001_010_1_0) begin
      errors++; $display("FAIL tick_fill_end got %b exp %b", obs, 11'b111_001_010_1_0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    modes(1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs !== 11'b001_001_100_1_0) begin
      errors++; $display("FAIL mode_start_together got %b exp %b", obs, 11'b001_001_100_1_0);
    end
  endtask

  task automatic test_reset_and_done_exit();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    modes(2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(7);
    checks++;
    if (obs !== 11'b010_010_100_1_0) begin
      errors++; $display("FAIL p011_rinse got %b exp %b", obs, 11'b010_010_100_1_0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== 11'b111_000_000_0_0) begin
      errors++; $display("FAIL reset_mid_run got %b exp %b", obs, 11'b111_000_000_0_0);
    end
    modes(3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(5);
    checks++;
    if (obs !== 11'b000_000_000_0_1) begin
      errors++; $display("FAIL p010_done got %b exp %b", obs, 11'b000_000_000_0_1);
    end
    modes(1);
    checks++;
    if (obs !== 11'b010_000_000_0_0) begin
      errors++; $display("FAIL done_exit_mode got %b exp %b", obs, 11'b010_000_000_0_0);
    end
    modes(1);
    checks++;
    if (obs !== 11'b110_000_000_0_0) begin
      errors++; $display("FAIL idle_after_done got %b exp %b", obs, 11'b110_000_000_0_0);
    end
  endtask

  task automatic test_random();
    logic t, m, s, r;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      t = ($urandom_range(0, 1) == 0);
      m = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 11) == 0);
      r = ($urandom_range(0, 299) == 0);
      step(t, m, s, r);
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL random cyc %0d got %b exp %b", i, obs, model_out());
      end
    end
  endtask

  initial begin
    bus.tick = 1'b0; bus.btn_mode = 1'b0; bus.btn_start = 1'b0;
    test_reset();
    test_mode();
    test_prog_wash_only();
    test_prog_rinse_dry();
    test_pause();
    test_simultaneous();
    test_reset_and_done_exit();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
